// File: rtl/cnt_sequencer_if.sv
// cnt_sequencer_if: bundles the command handshake and the down-counter control
// signals of cnt_sequencer.
//   Command side : start, load_val, div_steps, abort, clear (to sequencer)
//                  ready, busy, done, dec_count, error     (from sequencer)
//   Counter side : in, latch, div, dec                      (from sequencer)
//                  zero                                    (to sequencer)
// Modports: master = command issuer / counter side, slave = sequencer.
interface cnt_sequencer_if #(
    parameter int unsigned W = 8
) ();
    logic         start;
    logic [W-1:0] load_val;
    logic [2:0]   div_steps;
    logic         abort;
    logic         clear;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] dec_count;
    logic         error;
    logic [W-1:0] in;
    logic         latch;
    logic         div;
    logic         dec;
    logic         zero;

    modport master (
        output start, load_val, div_steps, abort, clear, zero,
        input  ready, busy, done, dec_count, error, in, latch, div, dec
    );

    modport slave (
        input  start, load_val, div_steps, abort, clear, zero,
        output ready, busy, done, dec_count, error, in, latch, div, dec
    );
endinterface

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: accepts one command (load value + divide steps), then drives a
// loadable down-counter with one latch strobe, div_steps divide strobes and
// decrement strobes until the counter reports zero. Reports completion with the
// number of decrements issued; raises a sticky error after TIMEOUT decrements.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   sq_if  : cnt_sequencer_if.slave (command handshake + counter controls)
module cnt_sequencer #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    cnt_sequencer_if.slave  sq_if
);

    localparam logic [W-1:0] TimeoutW = W'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDiv,
        StDec,
        StDone,
        StErr
    } state_e;

    state_e       r_state;
    state_e       w_state_next;
    logic [W-1:0] r_in;
    logic [2:0]   r_div_rem;
    logic [W-1:0] r_dec_cnt;
    logic [W-1:0] r_dec_count;
    logic         r_error;

    logic         w_ready;
    logic         w_busy;
    logic         w_done;
    logic         w_latch;
    logic         w_div;
    logic         w_dec;
    logic         w_accept;

    assign w_accept = (r_state == StIdle) && sq_if.start && !sq_if.abort;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_state_next = r_state;
        if (sq_if.abort) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: if (sq_if.start) w_state_next = StLoad;
                StLoad: w_state_next = (r_div_rem != 3'd0) ? StDiv : StDec;
                // Last divide pulse is the one issued with one step remaining
                StDiv:  if (r_div_rem == 3'd1) w_state_next = StDec;
                StDec: begin
                    if (sq_if.zero) begin
                        w_state_next = StDone;
                    end else if (r_dec_cnt == TimeoutW) begin
                        w_state_next = StErr;
                    end
                end
                StDone: w_state_next = StIdle;
                StErr:  if (sq_if.clear) w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Output decode from registered state; dec also gates on zero and timeout
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_latch = 1'b0;
        w_div   = 1'b0;
        w_dec   = 1'b0;
        case (r_state)
            StIdle: w_ready = 1'b1;
            StLoad: begin
                w_busy  = 1'b1;
                w_latch = 1'b1;
            end
            StDiv: begin
                w_busy = 1'b1;
                w_div  = 1'b1;
            end
            StDec: begin
                w_busy = 1'b1;
                w_dec  = !sq_if.zero && (r_dec_cnt != TimeoutW);
            end
            StDone: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: captured command, step counters, result and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in        <= '0;
            r_div_rem   <= 3'd0;
            r_dec_cnt   <= '0;
            r_dec_count <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in      <= sq_if.load_val;
                r_div_rem <= sq_if.div_steps;
                r_dec_cnt <= '0;
            end
            if (w_div) begin
                r_div_rem <= r_div_rem - 3'd1;
            end
            if (w_dec) begin
                r_dec_cnt <= r_dec_cnt + W'(1);
            end
            // Result is loaded on entry so it is valid alongside done
            if (w_state_next == StDone) begin
                r_dec_count <= r_dec_cnt;
            end
            if ((r_state == StErr) && sq_if.clear && !sq_if.abort) begin
                r_error <= 1'b0;
            end else if (w_state_next == StErr) begin
                r_error <= 1'b1;
            end
        end
    end

    assign sq_if.ready     = w_ready;
    assign sq_if.busy      = w_busy;
    assign sq_if.done      = w_done;
    assign sq_if.latch     = w_latch;
    assign sq_if.div       = w_div;
    assign sq_if.dec       = w_dec;
    assign sq_if.in        = r_in;
    assign sq_if.dec_count = r_dec_count;
    assign sq_if.error     = r_error;

endmodule

// File: doc/cnt_sequencer.md
# cnt_sequencer

Command sequencer that sits directly upstream of the loadable down-counter and drives its `in`, `latch`, `div` and `dec` controls. It accepts a single command (load value plus number of divide steps) through a ready/start handshake. It then issues a latch strobe, the requested divide strobes, and decrement strobes until the counter reports `zero`. It reports completion with the number of decrements issued, and raises a sticky error if `zero` does not arrive within a bounded number of decrements.

## Interface
Parameters:
- `W`, 8, data width of load value, `in` and `dec_count`.
- `TIMEOUT`, 255, maximum decrement strobes per command before error; range 1..2^W-1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command request; accepted only when `ready`=1.
- `load_val`  in  W  value to load into the counter; captured on acceptance.
- `div_steps`  in  3  number of divide strobes (0..7); captured on acceptance.
- `abort`  in  1  return to IDLE from any state on the next edge.
- `clear`  in  1  clears `error`, ERR back to IDLE.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in LOAD, DIV, DEC, DONE.
- `done`  out  1  one-cycle completion pulse.
- `dec_count`  out  W  decrement strobes issued by last completed command; held until next `done`.
- `error`  out  1  sticky timeout flag.
- `in`  out  W  registered load value to counter.
- `latch`  out  1  counter load strobe.
- `div`  out  1  counter divide strobe.
- `dec`  out  1  counter decrement strobe.
- `zero`  in  1  counter count==0; combinational from the counter's registered count.

## Operation
- States: IDLE, LOAD, DIV, DEC, DONE, ERR. All outputs registered or decoded from registered state only.
- IDLE: `ready`=1. On `start`=1, capture `load_val` into `in` and `div_steps` into the remaining-div counter; clear the internal decrement counter; go to LOAD.
- LOAD (1 cycle): `latch`=1. Next state is DIV if captured `div_steps`≠0, else DEC.
- DIV: `div`=1 every cycle; remaining count decrements. It issues exactly `div_steps` consecutive pulses, then goes to DEC.
- DEC, each cycle:
  - `zero`=1: `dec`=0, go to DONE.
  - Else if the internal counter equals `TIMEOUT`: `dec`=0, go to ERR.
  - Else: `dec`=1, internal counter +1.
- DONE (1 cycle): `done`=1, `dec_count` ← internal counter, then IDLE.
- ERR: `error`=1 and held. `ready`=0, `busy`=0, no strobes. `clear`=1 sets `error`←0 and returns to IDLE. `abort` also returns to IDLE but leaves `error` set.
- At most one of `latch`/`div`/`dec` is high in any cycle.
- `start` while `ready`=0 is ignored and not queued.
- `abort` has priority over every transition. The next edge forces IDLE, and all strobes are 0 from the following cycle. `done` does not pulse and `dec_count` is unchanged.
- `clear` outside ERR is ignored.
- Width rules:
  - Internal decrement counter is W bits and never wraps; the TIMEOUT check precedes increment.
  - `div_steps`=0 is legal and skips DIV.
  - `load_val`=0 is legal: DONE with `dec_count`=0.

## Timing
- Reset (asynchronous assert, synchronous-release in clock domain): state IDLE, `ready`=1, `busy`=0, `done`=0, `error`=0, `dec_count`=0, `in`=0, `latch`=0, `div`=0, `dec`=0.
- Reset mid-command aborts immediately. Strobes drop asynchronously, with no completion pulse.
- `start` sampled at edge E0:
  - LOAD (`latch`=1) in cycle 1.
  - DIV pulses in cycles 2..1+D.
  - First DEC cycle is 2+D.
- Each DEC pulse is reflected in `zero` the following cycle.
- For a counter reaching zero after N decrements, `done` is in cycle 3+D+N.
- Minimum command length: 3 cycles (`load_val`=0, D=0). The next `start` can be accepted at the edge ending the first IDLE cycle after DONE.

## Test plan
Bench uses a counter model: `latch` loads `in`; `div` shifts right by 1; `dec` subtracts 1; `zero` = (count==0).
- `load_val`=16, `div_steps`=2 -> latch cycle 1, div cycles 2-3 (count 4), dec cycles 4-7, `done` cycle 9, `dec_count`=4, `error`=0.
- `load_val`=0, `div_steps`=0 -> latch cycle 1, no div/dec, `done` cycle 3, `dec_count`=0.
- `TIMEOUT`=8, `load_val`=200, `div_steps`=0 -> exactly 8 dec pulses, ERR entered, `error`=1 held 10 cycles. A `start` during ERR is ignored; `clear` -> `error`=0, `ready`=1 next cycle.
- `load_val`=20 running, `abort` during 3rd dec pulse -> IDLE next edge, no further strobes, no `done`, `dec_count` keeps its previous value.
- `start` pulsed every cycle during a `load_val`=5 command -> only the first accepted, one `done`, `dec_count`=5. A second command accepted only after `ready` returns.
- `reset` asserted low during DIV of a `load_val`=64, `div_steps`=3 command -> strobes 0 immediately, all outputs at reset values, `ready`=1 after release.
